// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared types for the pipelined carry-lookahead adder.
//   op_e     : operation select (add with carry-in / subtract)
//   stage_t  : payload carried by every pipeline stage register: valid bit,
//              carry into the next slice, registered flags, the skewed
//              operands (A and the already-inverted B) and the partial sum
//              accumulated so far.
//   carry_in_sel : carry injected into slice 0 for a given operation.
// Operand fields are sized to ADDER_MAX_WIDTH so a single packed type serves
// every legal WIDTH; bits above WIDTH are held at zero.
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_MAX_WIDTH = 64;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic                       valid;
        logic                       carry;
        logic                       ovf;
        logic                       zero;
        logic [ADDER_MAX_WIDTH-1:0] a;
        logic [ADDER_MAX_WIDTH-1:0] b;
        logic [ADDER_MAX_WIDTH-1:0] sum;
    } stage_t;

    // Subtraction is A + ~B + 1, so the external carry is ignored there.
    function automatic logic carry_in_sel(input op_e op, input logic carry_i);
        return (op == OP_SUB) ? 1'b1 : carry_i;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// -----------------------------------------------------------------------------
// cla_slice
// Purely combinational carry-lookahead block for one SLICE-bit segment.
// Every internal carry is formed directly from the group generate/propagate
// of the bits below it and the slice carry-in, rather than rippling.
// Ports:
//   g         : per-bit generate  (a & b)
//   p         : per-bit propagate (a ^ b)
//   carry_in  : carry into bit 0 of the slice
//   sum       : slice sum bits
//   carry_out : carry out of the top bit of the slice
// -----------------------------------------------------------------------------
module cla_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] g,
    input  logic [SLICE-1:0] p,
    input  logic             carry_in,
    output logic [SLICE-1:0] sum,
    output logic             carry_out
);

    logic [SLICE:0] c;

    assign c[0] = carry_in;

    for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
        logic grp_g;
        logic grp_p;

        // Group generate/propagate over bits [gi:0]; carry into bit gi+1.
        always_comb begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int j = 0; j <= gi; j++) begin
                grp_g = g[j] | (p[j] & grp_g);
                grp_p = grp_p & p[j];
            end
        end

        assign c[gi+1] = grp_g | (grp_p & carry_in);
    end

    assign sum       = p ^ c[SLICE-1:0];
    assign carry_out = c[SLICE];

endmodule

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
// WIDTH-bit adder/subtractor split into STAGES equal slices. Stage k resolves
// slice k with a cla_slice fed by the carry registered in stage k-1, while the
// untouched upper operand slices and the finished lower sum bits travel with
// the transaction. Latency is STAGES cycles; one operand set accepted per
// cycle while the pipeline can advance.
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   valid_i / ready_o   : upstream handshake (ready_o = global advance enable)
//   a_i, b_i            : operands
//   sub_i               : 0 -> A + B + carry_i, 1 -> A - B
//   carry_i             : carry-in for add mode
//   valid_o / ready_i   : downstream handshake
//   sum_o               : result
//   carry_o             : carry out of the MSB (1 = no borrow when subtracting)
//   overflow_o          : signed overflow
//   zero_o              : result is zero (only ever set with valid_o)
// -----------------------------------------------------------------------------
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0 ||
        WIDTH > ADDER_MAX_WIDTH) begin : g_bad_params
        $error("pipelined_cla_adder: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    // The whole pipeline moves as one: it advances whenever the output slot
    // is empty or being consumed.
    logic en;

    op_e              op;
    logic [WIDTH-1:0] b_eff;
    stage_t           entry;

    assign op    = op_e'(sub_i);
    assign b_eff = (op == OP_SUB) ? ~b_i : b_i;

    always_comb begin
        entry       = '0;
        entry.valid = valid_i;
        entry.carry = carry_in_sel(op, carry_i);
        entry.a     = ADDER_MAX_WIDTH'(a_i);
        entry.b     = ADDER_MAX_WIDTH'(b_eff);
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam bit IS_LAST = (gi == LAST);

        stage_t           st_in;
        stage_t           st_out;
        stage_t           st_q;
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] s;
        logic             cout;

        if (gi == 0) begin : g_first
            assign st_in = entry;
        end else begin : g_next
            assign st_in = g_stage[gi-1].st_q;
        end

        assign g = st_in.a[gi*SLICE +: SLICE] & st_in.b[gi*SLICE +: SLICE];
        assign p = st_in.a[gi*SLICE +: SLICE] ^ st_in.b[gi*SLICE +: SLICE];

        cla_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .g         (g),
            .p         (p),
            .carry_in  (st_in.carry),
            .sum       (s),
            .carry_out (cout)
        );

        always_comb begin
            st_out                         = st_in;
            st_out.sum[gi*SLICE +: SLICE]  = s;
            st_out.carry                   = cout;
            // Flags are formed in the last stage so they are registered
            // together with the final sum bits. s[SLICE-1] is sum bit WIDTH-1.
            if (IS_LAST) begin
                st_out.ovf  = (st_in.a[WIDTH-1] == st_in.b[WIDTH-1]) &&
                              (s[SLICE-1] != st_in.a[WIDTH-1]);
                st_out.zero = st_in.valid && (st_out.sum[WIDTH-1:0] == '0);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                st_q <= '0;
            end else if (en) begin
                st_q <= st_out;
            end
        end
    end

    assign valid_o    = g_stage[LAST].st_q.valid;
    assign sum_o      = g_stage[LAST].st_q.sum[WIDTH-1:0];
    assign carry_o    = g_stage[LAST].st_q.carry;
    assign overflow_o = g_stage[LAST].st_q.ovf;
    assign zero_o     = g_stage[LAST].st_q.zero;

    assign en      = ready_i | ~valid_o;
    assign ready_o = en;

    // Operand copies and padding bits in the final register have no consumer;
    // they are collected here so they do not read as dangling logic.
    logic unused_final;
    assign unused_final = ^{g_stage[LAST].st_q.a, g_stage[LAST].st_q.b,
                            g_stage[LAST].st_q.sum};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
// Three adders (STAGES = 4, 1, 32; WIDTH = 32) share one stimulus stream.
// Each has its own in-order scoreboard; the 4-stage instance is also checked
// against a table of hand-computed vectors, latency, stall behaviour and a
// mid-flight reset.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        ovf;
        logic        z;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        c;
        logic        ovf;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_i;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;

    wire  [NDUT-1:0] ready_w;
    wire  [NDUT-1:0] valid_w;
    wire  [NDUT-1:0] c_w;
    wire  [NDUT-1:0] ovf_w;
    wire  [NDUT-1:0] z_w;
    wire  [31:0]     sum_w [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] fa, input logic [31:0] fb,
                                   input logic fsub, input logic fcin);
        logic [31:0] be;
        logic [32:0] t;
        exp_t        r;
        be    = fsub ? ~fb : fb;
        t     = {1'b0, fa} + {1'b0, be} + {32'd0, (fsub ? 1'b1 : fcin)};
        r.sum = t[31:0];
        r.c   = t[32];
        r.ovf = (fa[31] == be[31]) && (t[31] != fa[31]);
        r.z   = (t[31:0] == 32'd0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] need);
        n_tests++;
        if (got !== need) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, need);
        end
    endtask

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int ST = (gi == 0) ? 4 : ((gi == 1) ? 1 : 32);

        pipelined_cla_adder #(
            .WIDTH  (32),
            .STAGES (ST)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .valid_i    (valid_i),
            .ready_o    (ready_w[gi]),
            .a_i        (a),
            .b_i        (b),
            .sub_i      (sub),
            .carry_i    (cin),
            .valid_o    (valid_w[gi]),
            .ready_i    (ready_i),
            .sum_o      (sum_w[gi]),
            .carry_o    (c_w[gi]),
            .overflow_o (ovf_w[gi]),
            .zero_o     (z_w[gi])
        );

        exp_t q[$];

        // Sampled between edges: the coming rising edge transfers whatever
        // handshakes are visible now.
        always @(negedge clk) begin
            exp_t e;
            exp_t got;
            #2;
            if (!rst_n) begin
                q.delete();
            end else begin
                if (valid_w[gi] && ready_i) begin
                    got = {sum_w[gi], c_w[gi], ovf_w[gi], z_w[gi]};
                    n_tests++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_st%0d: unexpected result sum=%h, required no output", ST, sum_w[gi]);
                    end else begin
                        e = q.pop_front();
                        if (got !== e) begin
                            n_fail++;
                            $display("FAIL sb_st%0d: got sum=%h c=%b ovf=%b z=%b, required sum=%h c=%b ovf=%b z=%b",
                                     ST, got.sum, got.c, got.ovf, got.z, e.sum, e.c, e.ovf, e.z);
                        end
                    end
                end
                if (valid_i && ready_w[gi]) q.push_back(model(a, b, sub, cin));
            end
        end
    end

    vec_t vecs[12];

    task automatic run_vec(input int i);
        int lat;
        @(negedge clk);
        a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub; cin = vecs[i].cin;
        valid_i = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        valid_i = 1'b0;
        while (!valid_w[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        #1;
        $display("[TB] vec %0d: a=%h b=%h sub=%b cin=%b -> sum=%h c=%b ovf=%b z=%b lat=%0d",
                 i, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, sum_w[0], c_w[0], ovf_w[0], z_w[0], lat);
        check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
        check($sformatf("vec%0d_sum", i), 64'(sum_w[0]), 64'(vecs[i].sum));
        check($sformatf("vec%0d_carry", i), 64'(c_w[0]), 64'(vecs[i].c));
        check($sformatf("vec%0d_ovf", i), 64'(ovf_w[0]), 64'(vecs[i].ovf));
        check($sformatf("vec%0d_zero", i), 64'(z_w[0]), 64'(vecs[i].z));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev_sum;
        logic [2:0]  prev_flags;
        logic        prev_stall;
        int          idx;
        int          out_cnt;
        int          stall_seen;
        int          stale;
        int          sent;
        int          cyc;
        logic        acc;

        //              a             b             sub   cin   sum           c     ovf   z
        vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid_o", 64'(valid_w), 64'd0);
        check("reset_sum_o", 64'(sum_w[0]), 64'd0);
        check("reset_carry_o", 64'(c_w[0]), 64'd0);
        check("reset_overflow_o", 64'(ovf_w[0]), 64'd0);
        check("reset_zero_o", 64'(z_w[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 64'(ready_w[0]), 64'd1);

        // ---------------- directed table ----------------
        ready_i = 1'b1;
        for (int i = 0; i < 12; i++) run_vec(i);

        // ---------------- 8 back-to-back with a downstream stall ----------------
        idx = 0; out_cnt = 0; stall_seen = 0; prev_stall = 1'b0;
        prev_sum = '0; prev_flags = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            ready_i = !(c >= 3 && c <= 5);
            if (idx < 8) begin
                valid_i = 1'b1;
                a = 32'h1111_1111 * (idx + 1);
                b = 32'h0F0F_0F0F + idx;
                sub = idx[0];
                cin = idx[1];
            end else begin
                valid_i = 1'b0;
            end
            #1;
            if (prev_stall) begin
                check("stall_hold_valid", 64'(valid_w[0]), 64'd1);
                check("stall_hold_sum", 64'(sum_w[0]), 64'(prev_sum));
                check("stall_hold_flags", 64'({c_w[0], ovf_w[0], z_w[0]}), 64'(prev_flags));
            end
            if (valid_w[0] && !ready_i) begin
                check("stall_ready_o", 64'(ready_w[0]), 64'd0);
                stall_seen++;
            end
            if (valid_w[0] && ready_i) begin
                $display("[TB] burst out %0d: sum=%h c=%b ovf=%b z=%b", out_cnt, sum_w[0], c_w[0], ovf_w[0], z_w[0]);
                out_cnt++;
            end
            prev_stall = valid_w[0] && !ready_i;
            prev_sum   = sum_w[0];
            prev_flags = {c_w[0], ovf_w[0], z_w[0]};
            if (valid_i && ready_w[0]) idx++;
        end
        check("burst_results_out", 64'(out_cnt), 64'd8);
        check("burst_stall_cycles_seen", 64'(stall_seen > 0), 64'd1);
        check("burst_sb_empty", 64'(g_dut[0].q.size()), 64'd0);

        // ---------------- reset with three transactions in flight ----------------
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            valid_i = 1'b1;
            a = 32'hA5A5_0000 + k; b = 32'h0000_1234; sub = 1'b0; cin = 1'b0;
        end
        @(negedge clk);
        valid_i = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        $display("[TB] mid-flight reset: valid_o=%b", valid_w);
        check("midreset_valid_o", 64'(valid_w), 64'd0);
        check("midreset_sum_o", 64'(sum_w[0]), 64'd0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("release_ready_o", 64'(ready_w[0]), 64'd1);
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (valid_w != '0) stale++;
        end
        check("no_stale_results", 64'(stale), 64'd0);

        // ---------------- random stream, all three depths ----------------
        sent = 0; cyc = 0; acc = 1'b0; valid_i = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            ready_i = ($urandom_range(0, 9) != 0);
            if (!valid_i || acc) begin
                case ($urandom_range(0, 7))
                    0:       a = 32'hFFFF_FFFF;
                    1:       a = 32'h8000_0000;
                    2:       a = 32'h7FFF_FFFF;
                    default: a = $urandom;
                endcase
                b       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                sub     = $urandom_range(0, 1) == 1;
                cin     = $urandom_range(0, 1) == 1;
                valid_i = ($urandom_range(0, 7) != 0);
            end
            #1;
            acc = valid_i && ready_w[0];
            if (acc) sent++;
        end
        check("random_all_sent", 64'(sent), 64'd10000);
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (50) @(negedge clk);
        #3;
        for (int k = 0; k < NDUT; k++) begin
            $display("[TB] drain check dut %0d", k);
        end
        check("drain_sb_st4", 64'(g_dut[0].q.size()), 64'd0);
        check("drain_sb_st1", 64'(g_dut[1].q.size()), 64'd0);
        check("drain_sb_st32", 64'(g_dut[2].q.size()), 64'd0);
        check("drain_valid_o", 64'(valid_w), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
